multicycle_sequencer: RTL and testbench
=======================================

// Module: multicycle_sequencer
// PURPOSE
//  Multi-cycle control FSM for the simple RV32 core. Steps each instruction through
//  FETCH/DECODE/EXEC/MEM/WB and handshakes with instruction and data memory. Gates
//  the static decoder strobes (RegWrite, MemRead, MemWrite, MemToReg, Branch) into
//  single-cycle datapath write enables. Detects memory timeouts and illegal opcodes.
// PARAMETERS
//  MEM_TIMEOUT  16  cycles a req may stay unacked before fault; 0 disables timeout
//  CNT_W        32  width of instret counter
// PORTS
//  clk            in   1      single clock, rising edge
//  rst            in   1      asynchronous, active-high reset
//  run            in   1      1 = execute instructions; sampled at instruction boundaries
//  imem_req       out  1      instruction fetch request, held until imem_ack
//  imem_ack       in   1      fetch data valid this cycle
//  dmem_req       out  1      data access request, held until dmem_ack
//  dmem_we        out  1      1 = store, 0 = load; valid while dmem_req=1
//  dmem_ack       in   1      data access complete this cycle
//  dec_reg_write  in   1      decoder RegWrite
//  dec_mem_read   in   1      decoder MemRead
//  dec_mem_write  in   1      decoder MemWrite
//  dec_mem_to_reg in   1      decoder MemToReg
//  dec_branch     in   1      decoder Branch
//  dec_illegal    in   1      opcode not decodable
//  br_taken       in   1      branch condition result from ALU flags
//  ir_we          out  1      load instruction register
//  pc_we          out  1      advance PC
//  pc_sel_branch  out  1      1 = PC<-branch target, 0 = PC<-PC+4; valid with pc_we
//  reg_we         out  1      register-file write enable
//  wb_sel_mem     out  1      writeback mux: 1 = memory data, 0 = ALU result
//  state          out  3      current state encoding
//  fault          out  1      sticky; set on timeout or illegal opcode
//  instret        out  CNT_W  retired-instruction count, wraps modulo 2^CNT_W
// BEHAVIOUR
//  Encoding: IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 HALT=6. State, fault, instret
//  and timeout counter are registered. All strobes decode combinationally from state
//  and inputs. Reset: state=IDLE, fault=0, instret=0, all strobes 0.
//  IDLE: run=1 -> FETCH next cycle.
//  FETCH: imem_req=1. On imem_ack: ir_we=1 same cycle -> DECODE.
//  DECODE: 1 cycle. dec_illegal=1 -> HALT, fault<=1. Otherwise -> EXEC.
//  EXEC: 1 cycle. If dec_mem_read|dec_mem_write -> MEM.
//   Else if dec_branch: pc_we=1, pc_sel_branch=br_taken, retire -> boundary.
//   Else -> WB.
//  MEM: dmem_req=1, dmem_we=dec_mem_write. On dmem_ack: store -> pc_we=1, retire ->
//   boundary; load -> WB.
//  WB: reg_we=dec_reg_write, wb_sel_mem=dec_mem_to_reg, pc_we=1, retire -> boundary.
//  Boundary: run=1 -> FETCH; run=0 -> IDLE. run is ignored mid-instruction.
//  Retire: instret increments by 1 in the pc_we cycle; exactly one pc_we per instruction.
//  Timeout: counter clears on entry to FETCH/MEM and counts each req cycle without ack.
//   No ack in the MEM_TIMEOUT-th req cycle -> HALT, fault<=1, req drops next cycle.
//   An ack in that same cycle wins: no fault.
//  HALT: all strobes 0. Leave only via rst. Acks are ignored outside the matching state.
//  Decoder inputs must stay stable DECODE..WB; IR is not reloaded before next FETCH.
//  rst mid-operation: immediate IDLE. Req and strobes drop asynchronously; no partial retire.
// TESTING
//  R-type, run=1, imem_ack 2 cycles after req -> FETCH 3cy, DECODE, EXEC, WB;
//   ir_we x1, reg_we x1, pc_we x1, wb_sel_mem=0, instret=1.
//  LW, dmem_ack on 2nd MEM cycle -> dmem_we=0, WB reg_we=1, wb_sel_mem=1, instret+1.
//  SW, dmem_ack immediate -> dmem_we=1, pc_we in MEM ack cycle, reg_we never 1, no WB.
//  BEQ br_taken=1 -> EXEC pc_we=1, pc_sel_branch=1, then FETCH;
//   br_taken=0 -> pc_sel_branch=0.
//  MEM_TIMEOUT=8, imem_ack never -> 8th req cycle -> HALT, fault=1, imem_req=0;
//   ack in 8th cycle -> DECODE, fault=0.
//  rst asserted in MEM after 3 instr -> state=0, dmem_req=0, instret=0 async;
//   dec_illegal=1 -> HALT, fault=1.

Source files
------------

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM for the simple RV32 core.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB, handshakes with
// instruction and data memory, and turns the static decoder strobes into
// single-cycle datapath write enables. Memory timeouts and illegal opcodes
// park the machine in HALT with a sticky fault flag.
module multicycle_sequencer #(
  parameter int MEM_TIMEOUT = 16,  // req cycles allowed without ack; 0 disables
  parameter int CNT_W       = 32   // instret width
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  input  logic             dec_reg_write,
  input  logic             dec_mem_read,
  input  logic             dec_mem_write,
  input  logic             dec_mem_to_reg,
  input  logic             dec_branch,
  input  logic             dec_illegal,
  input  logic             br_taken,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_sel_branch,
  output logic             reg_we,
  output logic             wb_sel_mem,
  output logic [2:0]       state,
  output logic             fault,
  output logic [CNT_W-1:0] instret
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FETCH  = 3'd1;
  localparam logic [2:0] DECODE = 3'd2;
  localparam logic [2:0] EXEC   = 3'd3;
  localparam logic [2:0] MEM    = 3'd4;
  localparam logic [2:0] WB     = 3'd5;
  localparam logic [2:0] HALT   = 3'd6;

  // The counter holds the number of unacked req cycles already seen, so the
  // MEM_TIMEOUT-th req cycle is the one where it equals MEM_TIMEOUT-1.
  localparam int         TW    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST = TW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  logic [2:0]    state_next;
  logic [2:0]    boundary;
  logic [TW-1:0] tcnt;
  logic          tmo_last;
  logic          fault_set;

  assign tmo_last = (MEM_TIMEOUT != 0) && (tcnt == TLAST);
  assign boundary = run ? FETCH : IDLE;

  // Next-state and strobe decode; every strobe is a pure function of state and inputs.
  always_comb begin
    state_next    = state;
    imem_req      = 1'b0;
    ir_we         = 1'b0;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    pc_we         = 1'b0;
    pc_sel_branch = 1'b0;
    reg_we        = 1'b0;
    wb_sel_mem    = 1'b0;
    fault_set     = 1'b0;
    case (state)
      IDLE: begin
        if (run) state_next = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we      = 1'b1;
          state_next = DECODE;
        end else if (tmo_last) begin
          fault_set  = 1'b1;
          state_next = HALT;
        end
      end
      DECODE: begin
        if (dec_illegal) begin
          fault_set  = 1'b1;
          state_next = HALT;
        end else begin
          state_next = EXEC;
        end
      end
      EXEC: begin
        if (dec_mem_read || dec_mem_write) begin
          state_next = MEM;
        end else if (dec_branch) begin
          pc_we         = 1'b1;
          pc_sel_branch = br_taken;
          state_next    = boundary;
        end else begin
          state_next = WB;
        end
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = dec_mem_write;
        if (dmem_ack) begin
          if (dec_mem_write) begin
            pc_we      = 1'b1;
            state_next = boundary;
          end else begin
            state_next = WB;
          end
        end else if (tmo_last) begin
          fault_set  = 1'b1;
          state_next = HALT;
        end
      end
      WB: begin
        reg_we     = dec_reg_write;
        wb_sel_mem = dec_mem_to_reg;
        pc_we      = 1'b1;
        state_next = boundary;
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, sticky fault and retired-instruction counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      fault   <= 1'b0;
      instret <= '0;
    end else begin
      state <= state_next;
      if (fault_set) fault <= 1'b1;
      if (pc_we) instret <= instret + CNT_W'(1);
    end
  end

  // Timeout counter: cleared when a request phase begins, advanced per unacked req cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt <= '0;
    end else if ((state_next != state) && (state_next == FETCH || state_next == MEM)) begin
      tcnt <= '0;
    end else if ((state == FETCH && !imem_ack) || (state == MEM && !dmem_ack)) begin
      tcnt <= tcnt + TW'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: each cycle's expected outputs are
// queued when inputs are driven and popped for comparison on the falling edge.
module tb_multicycle_sequencer;

  localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3;
  localparam logic [2:0] MEM = 3'd4, WB = 3'd5, HALT = 3'd6;

  // Strobe vector order: imem_req ir_we dmem_req dmem_we pc_we pc_sel reg_we wb_sel
  localparam logic [7:0] S_NONE  = 8'b0000_0000;
  localparam logic [7:0] S_IREQ  = 8'b1000_0000;
  localparam logic [7:0] S_IRWE  = 8'b0100_0000;
  localparam logic [7:0] S_DREQ  = 8'b0010_0000;
  localparam logic [7:0] S_DWE   = 8'b0001_0000;
  localparam logic [7:0] S_PCWE  = 8'b0000_1000;
  localparam logic [7:0] S_PCSEL = 8'b0000_0100;
  localparam logic [7:0] S_REGWE = 8'b0000_0010;
  localparam logic [7:0] S_WBMEM = 8'b0000_0001;

  localparam int K_R = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_ILL = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0;
  logic        imem_req, imem_ack = 1'b0;
  logic        dmem_req, dmem_we, dmem_ack = 1'b0;
  logic        dec_reg_write = 1'b0, dec_mem_read = 1'b0, dec_mem_write = 1'b0;
  logic        dec_mem_to_reg = 1'b0, dec_branch = 1'b0, dec_illegal = 1'b0;
  logic        br_taken = 1'b0;
  logic        ir_we, pc_we, pc_sel_branch, reg_we, wb_sel_mem, fault;
  logic [2:0]  state;
  logic [31:0] instret;

  int          checks = 0;
  int          failures = 0;
  logic        exp_fault = 1'b0;
  logic [31:0] exp_instret = '0;
  logic [43:0] exp_q[$];

  multicycle_sequencer #(.MEM_TIMEOUT(8), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .run(run),
    .imem_req(imem_req), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .dec_reg_write(dec_reg_write), .dec_mem_read(dec_mem_read),
    .dec_mem_write(dec_mem_write), .dec_mem_to_reg(dec_mem_to_reg),
    .dec_branch(dec_branch), .dec_illegal(dec_illegal), .br_taken(br_taken),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel_branch(pc_sel_branch),
    .reg_we(reg_we), .wb_sel_mem(wb_sel_mem), .state(state),
    .fault(fault), .instret(instret)
  );

  always #5 clk = ~clk;

  // Pop the oldest expectation and compare against the live outputs.
  task automatic check(input string tag);
    logic [43:0] e;
    logic [43:0] o;
    o = {state, imem_req, ir_we, dmem_req, dmem_we, pc_we, pc_sel_branch,
         reg_we, wb_sel_mem, fault, instret};
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s scoreboard empty observed=%h", tag, o);
    end else begin
      e = exp_q.pop_front();
      assert (o === e) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
    end
  endtask

  // One clock cycle: drive acks, queue the expectation, compare mid-cycle.
  task automatic cyc(input string tag, input logic [2:0] st, input logic [7:0] s,
                     input logic ia, input logic da);
    imem_ack = ia;
    dmem_ack = da;
    exp_q.push_back({st, s, exp_fault, exp_instret});
    @(negedge clk);
    check(tag);
    @(posedge clk);
    #1;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
  endtask

  // Assert reset mid-cycle; everything must clear without waiting for an edge.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    exp_instret = '0;
    exp_fault   = 1'b0;
    exp_q.push_back({IDLE, S_NONE, 1'b0, 32'd0});
    check(tag);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic set_dec(input int kind);
    dec_reg_write  = (kind == K_R) || (kind == K_LW);
    dec_mem_read   = (kind == K_LW);
    dec_mem_write  = (kind == K_SW);
    dec_mem_to_reg = (kind == K_LW);
    dec_branch     = (kind == K_BEQ);
    dec_illegal    = (kind == K_ILL);
  endtask

  task automatic fetch(input string tag, input int ilat);
    for (int i = 0; i < ilat; i++) cyc(tag, FETCH, S_IREQ, 1'b0, 1'b0);
    cyc(tag, FETCH, S_IREQ | S_IRWE, 1'b1, 1'b0);
  endtask

  // Full instruction starting in FETCH; a stray dmem_ack in DECODE must be ignored.
  task automatic instr(input string tag, input int kind, input int ilat,
                       input int dlat, input logic br);
    set_dec(kind);
    br_taken = br;
    fetch(tag, ilat);
    cyc(tag, DECODE, S_NONE, 1'b0, 1'b1);
    case (kind)
      K_R: begin
        cyc(tag, EXEC, S_NONE, 1'b0, 1'b0);
        cyc(tag, WB, S_REGWE | S_PCWE, 1'b0, 1'b0);
      end
      K_LW: begin
        cyc(tag, EXEC, S_NONE, 1'b0, 1'b0);
        for (int i = 0; i < dlat; i++) cyc(tag, MEM, S_DREQ, 1'b0, 1'b0);
        cyc(tag, MEM, S_DREQ, 1'b0, 1'b1);
        cyc(tag, WB, S_REGWE | S_WBMEM | S_PCWE, 1'b0, 1'b0);
      end
      K_SW: begin
        cyc(tag, EXEC, S_NONE, 1'b0, 1'b0);
        for (int i = 0; i < dlat; i++) cyc(tag, MEM, S_DREQ | S_DWE, 1'b0, 1'b0);
        cyc(tag, MEM, S_DREQ | S_DWE | S_PCWE, 1'b0, 1'b1);
      end
      default: begin
        cyc(tag, EXEC, br ? (S_PCWE | S_PCSEL) : S_PCWE, 1'b0, 1'b0);
      end
    endcase
    exp_instret++;
    $display("instr %s kind=%0d instret_expected=%0d", tag, kind, exp_instret);
  endtask

  initial begin
    #2;
    do_reset("reset");
    run = 1'b1;
    cyc("idle_go", IDLE, S_NONE, 1'b0, 1'b0);

    instr("rtype", K_R, 2, 0, 1'b0);
    instr("lw", K_LW, 0, 1, 1'b0);
    instr("sw", K_SW, 1, 0, 1'b0);
    instr("beq_t", K_BEQ, 0, 0, 1'b1);
    run = 1'b0;  // dropped mid-instruction: only the boundary sees it
    instr("beq_nt", K_BEQ, 0, 0, 1'b0);
    cyc("idle_hold", IDLE, S_NONE, 1'b1, 1'b1);
    cyc("idle_hold", IDLE, S_NONE, 1'b0, 1'b0);
    run = 1'b1;
    cyc("idle_go", IDLE, S_NONE, 1'b0, 1'b0);

    // Fetch never acked: 8 req cycles, then HALT with fault.
    set_dec(K_R);
    for (int i = 0; i < 8; i++) cyc("imem_tmo", FETCH, S_IREQ, 1'b0, 1'b0);
    exp_fault = 1'b1;
    cyc("halt_tmo", HALT, S_NONE, 1'b1, 1'b1);
    cyc("halt_tmo", HALT, S_NONE, 1'b0, 1'b0);

    do_reset("reset_halt");
    cyc("idle_go", IDLE, S_NONE, 1'b0, 1'b0);
    // Ack arrives in the 8th req cycle: no fault.
    instr("ack_last", K_R, 7, 0, 1'b0);
    instr("lw2", K_LW, 1, 0, 1'b0);
    instr("sw2", K_SW, 0, 2, 1'b0);

    // Reset while a load sits in MEM.
    set_dec(K_LW);
    fetch("lw_rst", 0);
    cyc("lw_rst", DECODE, S_NONE, 1'b0, 1'b0);
    cyc("lw_rst", EXEC, S_NONE, 1'b0, 1'b0);
    cyc("lw_rst", MEM, S_DREQ, 1'b0, 1'b0);
    do_reset("reset_mem");

    // Illegal opcode halts after DECODE.
    cyc("idle_go", IDLE, S_NONE, 1'b0, 1'b0);
    set_dec(K_ILL);
    fetch("illegal", 0);
    cyc("illegal", DECODE, S_NONE, 1'b0, 1'b0);
    exp_fault = 1'b1;
    cyc("halt_ill", HALT, S_NONE, 1'b1, 1'b1);
    cyc("halt_ill", HALT, S_NONE, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
